// File: rtl/addr_sequencer.sv
// Instruction-cycle address sequencer: a FETCH phase drives the PC address, then a DATA
// phase drives the address of a round-robin-selected requesting channel.
module addr_sequencer #(
   parameter int ADDR_W    = 13,
   parameter int NUM_CH    = 2,
   parameter int FETCH_CYC = 4,
   parameter int DATA_CYC  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic [ADDR_W-1:0]        pc_addr,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH-1:0]        ch_req,
   output logic [ADDR_W-1:0]        addr,
   output logic                     fetch,
   output logic [NUM_CH-1:0]        ch_gnt,
   output logic                     addr_valid
);

   localparam int MAX_CYC = (FETCH_CYC > DATA_CYC) ? FETCH_CYC : DATA_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_CYC - 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_CYC - 1);
   localparam logic [GW-1:0]    LAST_RST   = GW'(NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [ADDR_W-1:0] addr_n;
   logic              fetch_n, valid_n;
   logic [NUM_CH-1:0] gnt_n;
   logic [GW-1:0]     last_gnt, last_n;

   logic [GW-1:0]     win, idx;
   logic              win_found;
   logic [ADDR_W-1:0] win_addr;
   logic [NUM_CH-1:0] win_onehot;

   // Round-robin search: start one past the last winner, first requester wins.
   always_comb begin
      win        = last_gnt;
      win_found  = 1'b0;
      idx        = '0;
      win_addr   = '0;
      win_onehot = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = GW'((int'(last_gnt) + 1 + k) % NUM_CH);
         if (!win_found && ch_req[idx]) begin
            win_found = 1'b1;
            win       = idx;
         end
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (GW'(k) == win) begin
            win_addr      = ch_addr[k*ADDR_W +: ADDR_W];
            win_onehot[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      addr_n  = addr;
      fetch_n = fetch;
      gnt_n   = ch_gnt;
      valid_n = addr_valid;
      last_n  = last_gnt;
      case (state)
         IDLE: begin
            if (ena) begin
               state_n = FETCH;
               cnt_n   = '0;
               addr_n  = pc_addr;
               fetch_n = 1'b1;
               gnt_n   = '0;
               valid_n = 1'b1;
            end
         end
         FETCH: begin
            if (cnt == FETCH_LAST) begin
               state_n = DATA;
               cnt_n   = '0;
               fetch_n = 1'b0;
               if (win_found) begin
                  gnt_n   = win_onehot;
                  addr_n  = win_addr;
                  valid_n = 1'b1;
                  last_n  = win;
               end else begin
                  gnt_n   = '0;
                  valid_n = 1'b0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            // ena is only consulted here, so a cycle in flight always completes.
            if (cnt == DATA_LAST) begin
               cnt_n = '0;
               gnt_n = '0;
               if (ena) begin
                  state_n = FETCH;
                  addr_n  = pc_addr;
                  fetch_n = 1'b1;
                  valid_n = 1'b1;
               end else begin
                  state_n = IDLE;
                  fetch_n = 1'b0;
                  valid_n = 1'b0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            fetch_n = 1'b0;
            gnt_n   = '0;
            valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         addr       <= '0;
         fetch      <= 1'b0;
         ch_gnt     <= '0;
         addr_valid <= 1'b0;
         last_gnt   <= LAST_RST;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         addr       <= addr_n;
         fetch      <= fetch_n;
         ch_gnt     <= gnt_n;
         addr_valid <= valid_n;
         last_gnt   <= last_n;
      end
   end

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: per-cycle vector table for the 2-channel default build,
// hand sequences for async reset, and a 4-channel build with short phases.
module tb_addr_sequencer;

   localparam int W = 19;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        ena = 1'b0;
   logic [12:0] pc = '0;
   logic [25:0] cha = '0;
   logic [1:0]  req = '0;
   logic [12:0] addr;
   logic        fetch;
   logic [1:0]  gnt;
   logic        valid;

   logic        ena4 = 1'b0;
   logic [12:0] pc4 = '0;
   logic [51:0] cha4 = '0;
   logic [3:0]  req4 = '0;
   logic [12:0] addr4;
   logic        fetch4;
   logic [3:0]  gnt4;
   logic        valid4;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic        ena;
      logic [12:0] pc;
      logic [1:0]  req;
      logic [25:0] cha;
      logic [12:0] e_addr;
      logic        e_fetch;
      logic [1:0]  e_gnt;
      logic        e_valid;
   } vec_t;
   vec_t tbl[$];

   localparam logic [25:0] CHA = {13'h1F0, 13'h020};

   addr_sequencer dut (
      .clk(clk), .rst(rst), .ena(ena), .pc_addr(pc), .ch_addr(cha), .ch_req(req),
      .addr(addr), .fetch(fetch), .ch_gnt(gnt), .addr_valid(valid)
   );

   addr_sequencer #(.ADDR_W(13), .NUM_CH(4), .FETCH_CYC(2), .DATA_CYC(3)) dut4 (
      .clk(clk), .rst(rst), .ena(ena4), .pc_addr(pc4), .ch_addr(cha4), .ch_req(req4),
      .addr(addr4), .fetch(fetch4), .ch_gnt(gnt4), .addr_valid(valid4)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   function automatic logic [W-1:0] pk(input logic [12:0] a, input logic f,
                                       input logic [3:0] g, input logic v);
      return {a, f, g, v};
   endfunction

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got={addr,fetch,gnt,valid}=%h exp=%h", nm, got, exp);
      end
   endtask

   // driver tasks
   task automatic add_row(input logic e, input logic [12:0] p, input logic [1:0] r,
                          input logic [25:0] c, input logic [12:0] ea, input logic ef,
                          input logic [1:0] eg, input logic ev);
      vec_t v;
      v.ena = e; v.pc = p; v.req = r; v.cha = c;
      v.e_addr = ea; v.e_fetch = ef; v.e_gnt = eg; v.e_valid = ev;
      tbl.push_back(v);
   endtask

   function automatic logic [12:0] rnd13();
      return 13'($urandom_range(0, 8191));
   endfunction

   // One instruction cycle: 4 FETCH rows then 4 DATA rows. Only the entry rows'
   // pc / req / ch_addr matter; all other rows carry random noise.
   task automatic add_instr(input logic [12:0] p, input logic [1:0] rq, input logic [1:0] rq_mid,
                            input logic ena_mid, input logic [12:0] d_addr,
                            input logic [1:0] d_gnt, input logic d_valid);
      add_row(1'b1, p, rq_mid, {rnd13(), rnd13()}, p, 1'b1, 2'b00, 1'b1);
      for (int i = 1; i < 4; i++)
         add_row(ena_mid, rnd13(), rq_mid, {rnd13(), rnd13()}, p, 1'b1, 2'b00, 1'b1);
      add_row(ena_mid, rnd13(), rq, CHA, d_addr, 1'b0, d_gnt, d_valid);
      for (int i = 1; i < 4; i++)
         add_row(ena_mid, rnd13(), rq_mid, {rnd13(), rnd13()}, d_addr, 1'b0, d_gnt, d_valid);
   endtask

   task automatic add_idle(input logic [12:0] a);
      add_row(1'b0, rnd13(), 2'($urandom_range(0, 3)), {rnd13(), rnd13()}, a, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic step_vec(input string nm, input vec_t v);
      logic [W-1:0] e;
      @(negedge clk);
      ena = v.ena; pc = v.pc; req = v.req; cha = v.cha;
      exp_q.push_back(pk(v.e_addr, v.e_fetch, {2'b00, v.e_gnt}, v.e_valid));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(nm, pk(addr, fetch, {2'b00, gnt}, valid), e);
   endtask

   task automatic run_tbl(input string nm, input int n);
      for (int i = 0; i < n; i++) step_vec($sformatf("%s_row%0d", nm, i), tbl[i]);
   endtask

   task automatic step4(input logic e, input logic [12:0] ea, input logic ef,
                        input logic [3:0] eg, input logic ev, input string nm);
      logic [W-1:0] x;
      @(negedge clk);
      ena4 = e;
      req4 = 4'b1010;
      exp_q.push_back(pk(ea, ef, eg, ev));
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check(nm, pk(addr4, fetch4, gnt4, valid4), x);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", pk(addr, fetch, {2'b00, gnt}, valid), '0);
      check("reset_state4", pk(addr4, fetch4, gnt4, valid4), '0);
      rst = 1'b0;

      // main table: round robin, no-request DATA, ena drop, idle hold
      tbl.delete();
      add_instr(13'h0A5, 2'b11, 2'($urandom_range(0, 3)), 1'b1, 13'h020, 2'b01, 1'b1);
      add_instr(13'h111, 2'b11, 2'($urandom_range(0, 3)), 1'b1, 13'h1F0, 2'b10, 1'b1);
      add_instr(13'h0A5, 2'b11, 2'($urandom_range(0, 3)), 1'b1, 13'h020, 2'b01, 1'b1);
      add_instr(13'h0A5, 2'b00, 2'b10, 1'b1, 13'h0A5, 2'b00, 1'b0);
      add_instr(13'h0C3, 2'b11, 2'($urandom_range(0, 3)), 1'b1, 13'h1F0, 2'b10, 1'b1);
      add_instr(13'h0A5, 2'b01, 2'($urandom_range(0, 3)), 1'b0, 13'h020, 2'b01, 1'b1);
      add_idle(13'h020);
      add_idle(13'h020);
      add_instr(13'h1234, 2'b10, 2'($urandom_range(0, 3)), 1'b1, 13'h1F0, 2'b10, 1'b1);
      add_idle(13'h1F0);
      run_tbl("main", tbl.size());

      // async reset in DATA cycle 2 (this cycle grants ch0, leaving last_gnt=0)
      tbl.delete();
      add_instr(13'h0A5, 2'b11, 2'b11, 1'b1, 13'h020, 2'b01, 1'b1);
      run_tbl("pre_rst", 6);
      rst = 1'b1;
      #1;
      check("async_rst", pk(addr, fetch, {2'b00, gnt}, valid), '0);
      @(posedge clk);
      #1;
      check("rst_hold", pk(addr, fetch, {2'b00, gnt}, valid), '0);
      @(negedge clk);
      rst = 1'b0;
      ena = 1'b0;
      tbl.delete();
      add_instr(13'h0B7, 2'b11, 2'($urandom_range(0, 3)), 1'b1, 13'h020, 2'b01, 1'b1);
      add_idle(13'h020);
      run_tbl("post_rst", tbl.size());

      // 4-channel build: 2-cycle FETCH, 3-cycle DATA, req 1010 alternates ch1/ch3
      pc4  = 13'h042;
      cha4 = {13'h103, 13'h102, 13'h101, 13'h100};
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 2; i++)
            step4(1'b1, 13'h042, 1'b1, 4'b0000, 1'b1, $sformatf("ch4_fetch_c%0d_%0d", c, i));
         for (int i = 0; i < 3; i++) begin
            if (c == 1)
               step4(1'b1, 13'h103, 1'b0, 4'b1000, 1'b1, $sformatf("ch4_data_c%0d_%0d", c, i));
            else
               step4(c != 2, 13'h101, 1'b0, 4'b0010, 1'b1, $sformatf("ch4_data_c%0d_%0d", c, i));
         end
      end
      step4(1'b0, 13'h101, 1'b0, 4'b0000, 1'b0, "ch4_idle");

      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
